// File: rtl/ber_pkg.sv
// Shared definitions for the BER checker: state encoding, default sizing
// and the saturating increment used for the cumulative error count.
package ber_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCK   = 1'b1
    } ber_state_e;

    localparam int unsigned DEF_MAX_DLY  = 32;
    localparam int unsigned DEF_DLY_W    = 5;
    localparam int unsigned DEF_SYNC_WIN = 64;
    localparam int unsigned DEF_SYNC_THR = 2;
    localparam int unsigned DEF_MEAS_WIN = 1024;
    localparam int unsigned DEF_LOSS_THR = 128;
    localparam int unsigned DEF_CNT_W    = 16;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ref_delay_line.sv
// PN reference history with a selectable tap; tap 0 is the live reference bit,
// tap d is the reference bit from d strobes earlier.
module ref_delay_line
    import ber_pkg::*;
#(
    parameter int unsigned MAX_DLY = DEF_MAX_DLY,
    parameter int unsigned DLY_W   = DEF_DLY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             ref_bit,
    input  logic [DLY_W-1:0] delay,
    output logic             tap_bit
);

    logic [MAX_DLY-2:0] hist_q;
    logic [MAX_DLY-2:0] hist_d;
    logic [MAX_DLY-1:0] taps;

    always_comb begin
        taps    = {hist_q, ref_bit};
        tap_bit = taps[delay];
        hist_d  = hist_q;
        if (bit_en) begin
            hist_d = taps[MAX_DLY-2:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/ber_checker.sv
// Bit-error-rate checker: searches for the decoder pipeline delay against the
// PN reference, then reports per-window and cumulative error counts.
module ber_checker
    import ber_pkg::*;
#(
    parameter int unsigned MAX_DLY  = DEF_MAX_DLY,
    parameter int unsigned DLY_W    = DEF_DLY_W,
    parameter int unsigned SYNC_WIN = DEF_SYNC_WIN,
    parameter int unsigned SYNC_THR = DEF_SYNC_THR,
    parameter int unsigned MEAS_WIN = DEF_MEAS_WIN,
    parameter int unsigned LOSS_THR = DEF_LOSS_THR,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             ref_bit,
    input  logic             dec_bit,
    output logic             locked,
    output logic [DLY_W-1:0] delay,
    output logic [CNT_W-1:0] win_err,
    output logic             meas_valid,
    output logic [31:0]      total_err
);

    localparam logic [DLY_W-1:0] DLY_LAST  = DLY_W'(MAX_DLY - 1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_WIN - 1);
    localparam logic [CNT_W-1:0] MEAS_LAST = CNT_W'(MEAS_WIN - 1);
    localparam logic [CNT_W-1:0] SYNC_LIM  = CNT_W'(SYNC_THR);
    localparam logic [CNT_W-1:0] LOSS_LIM  = CNT_W'(LOSS_THR);

    ber_state_e       state_q,      state_d;
    logic [DLY_W-1:0] delay_q,      delay_d;
    logic [CNT_W-1:0] bcnt_q,       bcnt_d;
    logic [CNT_W-1:0] ecnt_q,       ecnt_d;
    logic [CNT_W-1:0] win_err_q,    win_err_d;
    logic             meas_valid_q, meas_valid_d;
    logic [31:0]      total_err_q,  total_err_d;

    logic             tap_bit;
    logic             err;
    logic [CNT_W-1:0] ecnt_inc;
    logic [DLY_W-1:0] delay_inc;

    ref_delay_line #(
        .MAX_DLY (MAX_DLY),
        .DLY_W   (DLY_W)
    ) u_ref_delay_line (
        .clk     (clk),
        .rst     (rst),
        .bit_en  (bit_en),
        .ref_bit (ref_bit),
        .delay   (delay_q),
        .tap_bit (tap_bit)
    );

    always_comb begin
        state_d      = state_q;
        delay_d      = delay_q;
        bcnt_d       = bcnt_q;
        ecnt_d       = ecnt_q;
        win_err_d    = win_err_q;
        total_err_d  = total_err_q;
        meas_valid_d = 1'b0;

        err       = dec_bit ^ tap_bit;
        ecnt_inc  = ecnt_q + CNT_W'(err);
        delay_inc = (delay_q == DLY_LAST) ? '0 : delay_q + 1'b1;

        if (bit_en) begin
            bcnt_d = bcnt_q + 1'b1;
            ecnt_d = ecnt_inc;
            case (state_q)
                SEARCH: begin
                    // Window decision includes the closing strobe's own error.
                    if (bcnt_q == SYNC_LAST) begin
                        bcnt_d = '0;
                        ecnt_d = '0;
                        if (ecnt_inc <= SYNC_LIM) begin
                            state_d = LOCK;
                        end else begin
                            delay_d = delay_inc;
                        end
                    end
                end
                LOCK: begin
                    if (err) begin
                        total_err_d = sat_inc(total_err_q);
                    end
                    if (bcnt_q == MEAS_LAST) begin
                        bcnt_d       = '0;
                        ecnt_d       = '0;
                        win_err_d    = ecnt_inc;
                        meas_valid_d = 1'b1;
                        if (ecnt_inc > LOSS_LIM) begin
                            state_d = SEARCH;
                            delay_d = delay_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SEARCH;
            delay_q      <= '0;
            bcnt_q       <= '0;
            ecnt_q       <= '0;
            win_err_q    <= '0;
            meas_valid_q <= 1'b0;
            total_err_q  <= '0;
        end else begin
            state_q      <= state_d;
            delay_q      <= delay_d;
            bcnt_q       <= bcnt_d;
            ecnt_q       <= ecnt_d;
            win_err_q    <= win_err_d;
            meas_valid_q <= meas_valid_d;
            total_err_q  <= total_err_d;
        end
    end

    assign locked     = (state_q == LOCK);
    assign delay      = delay_q;
    assign win_err    = win_err_q;
    assign meas_valid = meas_valid_q;
    assign total_err  = total_err_q;

endmodule

// File: doc/ber_checker.md
# ber_checker

Bit-error-rate checker downstream of the Viterbi decoder in the convolutional-code link. It compares the decoded stream `data_out` against the PN reference `Q` from the M-series generator. It finds the decoder's pipeline delay on its own, then reports per-window and cumulative error counts. It runs on the 20 MHz system clock, with a one-cycle strobe marking each 5 kHz decoded bit.

## Interface
Parameters:
- `MAX_DLY`, 32: number of candidate delays searched (0..MAX_DLY-1 bits).
- `DLY_W`, 5: width of delay index, equal to clog2(MAX_DLY).
- `SYNC_WIN`, 64: bits examined per candidate delay during search.
- `SYNC_THR`, 2: maximum errors in a sync window that still declares lock.
- `MEAS_WIN`, 1024: bits per measurement window while locked.
- `LOSS_THR`, 128: errors in one measurement window above which lock is dropped.
- `CNT_W`, 16: width of window error counter. It must hold MEAS_WIN.

Ports:
- `clk` in 1: system clock (20 MHz).
- `rst` in 1: synchronous, active-high reset.
- `bit_en` in 1: one-`clk` strobe, one per decoded bit.
- `ref_bit` in 1: PN reference bit (`Q`), valid while `bit_en` is high.
- `dec_bit` in 1: decoded bit (`data_out`), valid while `bit_en` is high.
- `locked` out 1: high while in the LOCK state.
- `delay` out DLY_W: current candidate or locked delay.
- `win_err` out CNT_W: error count of the last completed measurement window.
- `meas_valid` out 1: one-cycle pulse when `win_err` updates.
- `total_err` out 32: cumulative errors while locked, saturating at 2^32-1.

## Operation
- **Reference history:**
  - Shift register `hist` of MAX_DLY-1 bits, shifted in from `ref_bit` on each `bit_en`.
  - Tap d = ref_bit from d strobes earlier. Tap 0 is the current `ref_bit`.
- **Error bit:** err = `dec_bit` XOR tap[`delay`], evaluated only when `bit_en` is high.
- **SEARCH state** (the reset state):
  - Counts bits (`bcnt`) and errors (`ecnt`) for the current `delay`.
  - On the strobe completing SYNC_WIN bits, including that strobe's err:
    - If ecnt ≤ SYNC_THR: go to LOCK and keep `delay`.
    - Otherwise: `delay` ← `delay`+1, wrapping from MAX_DLY-1 to 0, and stay in SEARCH.
  - Both counters clear on every window boundary.
- **LOCK state:**
  - Counts bits and errors per MEAS_WIN window. Each err also increments `total_err`, which saturates.
  - On the strobe completing the window:
    - `win_err` ← ecnt, including the final err.
    - `meas_valid` pulses.
    - Counters clear.
    - If ecnt > LOSS_THR: go to SEARCH, `delay` ← `delay`+1 with wrap. `total_err` is held, not cleared.
- No strobe is lost across state or delay changes. The next strobe uses the new state and delay.
- `hist` keeps running in all states. It is never flushed on a delay change.

## Timing
- All state is updated on posedge `clk`. Nothing changes in cycles where `bit_en` is low.
- `locked`, `delay`, `win_err` and `total_err` are registered. They change on the edge that samples the deciding strobe, so they are visible in the following cycle.
- `meas_valid` is high exactly for the cycle after the window-closing strobe. `bit_en` on consecutive cycles is legal and handled at full rate.
- Reset values: `locked`=0, `delay`=0, `win_err`=0, `meas_valid`=0, `total_err`=0, `hist`=0, state=SEARCH, counters=0.
- Reset mid-window discards the partial counts. `rst` has priority over `bit_en` in the same cycle.
- Latency from a bit strobe to its contribution in `total_err` is 1 cycle.

## Structure
- **Package `ber_pkg`:**
  - State typedef: SEARCH=1'b0, LOCK=1'b1.
  - Default parameter constants.
  - Saturating-increment function for `total_err`.
- **Sub-module `ref_delay_line`:**
  - Holds `hist` plus the tap multiplexer.
  - Inputs: `clk`, `rst`, `bit_en`, `ref_bit`, `delay`. Output: the selected tap bit (combinational).
- The top level holds the FSM, counters and output registers.

## Test plan
- **Zero delay:** `dec_bit`=`ref_bit`, PN9 reference, strobe every 4000 clk → `locked`=1 after 64 strobes, `delay`=0; first `meas_valid` after 1024 more strobes with `win_err`=0.
- **Delay 13:** `dec_bit`=ref delayed 13 bits → search steps through delays 0..12 (64 strobes each) and locks with `delay`=13 on strobe 14×64=896.
- **Injected errors:** locked at delay 13, flip 1 bit in every 10 → `win_err`=102 or 103 per window, `total_err` accumulates, `locked` stays 1.
- **Loss of lock:** locked, then invert every second bit (512 errors per window) → after window close `locked`=0 and `delay`=14; search wraps past 31 to 0 and relocks at 13.
- **Reset and back-to-back strobes:** assert `rst` mid-window → all outputs reach their reset values next cycle. Separately, `bit_en` high continuously → counts exact, `meas_valid` every 1024 cycles.
- **Saturation:** force `total_err` near 2^32-2 through preload in the bench and inject 3 errors → reads 2^32-1 and holds.
